r2r_dac_streamer: RTL and testbench
===================================

R2R_DAC_STREAMER -- requirements
Module: r2r_dac_streamer

Interface
REQ-001 Parameter DIV, default 100_000: clk cycles per DAC update period; legal range 2 or more.
REQ-002 Parameter FIFO_DEPTH, default 4: sample buffer entries; must be a power of 2, 2 or more.
REQ-003 Port clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port enable  in  1  streaming enable, level-sensitive.
REQ-006 Port sample_data  in  8  sample code to play.
REQ-007 Port sample_valid  in  1  producer offers sample_data.
REQ-008 Port sample_ready  out  1  block accepts a sample this cycle.
REQ-009 Port underrun_clr  in  1  clears the sticky underrun flag.
REQ-010 Port R2R_out  out  8  registered code to the external R2R ladder.
REQ-011 Port dac_update  out  1  one-cycle pulse marking a new R2R_out value.
REQ-012 Port underrun  out  1  sticky flag: an update period found the FIFO empty.
REQ-013 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A push occurs when sample_valid and sample_ready are both 1; sample_ready = !full, with no combinational path from sample_valid.
REQ-015 Pushing when full is impossible; data order is strict FIFO.
REQ-016 State machine states are IDLE, PRIME and RUN.
- IDLE: enable=0.
- PRIME: filling the FIFO.
- RUN: playing samples.
REQ-017 IDLE->PRIME when enable=1; PRIME->RUN when fifo_level >= FIFO_DEPTH/2; any state->IDLE when enable=0.
REQ-018 Pushes are accepted in every state, including IDLE.
REQ-019 Period counter behaviour:
- Held at 0 outside RUN.
- In RUN, counts 0..DIV-1 and wraps.
- The strobe is the cycle where count==DIV-1.
- The first strobe comes DIV cycles after RUN entry.
REQ-020 Strobe with FIFO non-empty:
- Head is popped.
- R2R_out is loaded at the end of the strobe cycle.
- dac_update is 1 for exactly the following cycle.
REQ-021 Strobe with FIFO empty: R2R_out holds its value, dac_update stays 0, underrun is set, and the state stays RUN.
REQ-022 Push and pop in the same cycle: fifo_level is unchanged; a push into an empty FIFO is not poppable in that same cycle.
REQ-023 Entering IDLE loads R2R_out with MID_CODE (8'h80) on the next edge, with no dac_update pulse; FIFO contents are retained.
REQ-024 underrun_clr=1 clears underrun; if a set condition occurs in the same cycle, the set wins.
REQ-025 R2R_out changes only on dac_update or IDLE entry, so there are no intermediate codes on the ladder.

Reset
REQ-026 On reset assertion, immediately and asynchronously:
- state=IDLE, counter=0, FIFO emptied, fifo_level=0.
- R2R_out=8'h80, dac_update=0, underrun=0.
- sample_ready=1 after release.
REQ-027 Reset mid-period discards the partial period and all buffered samples.

Configuration
REQ-028 With macro R2R_DAC_UNDERRUN_CNT_EN defined:
- Adds output port underrun_count, out, 16 bits.
- It is a saturating count of empty-FIFO strobes.
- It is cleared by reset and by underrun_clr; an increment in the same cycle as underrun_clr yields 1.
REQ-029 Without R2R_DAC_UNDERRUN_CNT_EN, the port and its counter are absent and all other behaviour is identical.

Structure
REQ-030 Package r2r_dac_pkg holds:
- DAC_WIDTH=8.
- MID_CODE=8'h80.
- The state enum type (IDLE, PRIME, RUN).
REQ-031 Sub-module r2r_sample_fifo (parameter DEPTH) provides:
- Ports: push, pop, data in/out, full, empty, level.
- Synchronous behaviour with asynchronous active-high reset.
REQ-032 The period counter and FSM are implemented inline; the existing free-running divider is not reused, because it lacks reset and gating.

Verification (DIV=4, FIFO_DEPTH=4)
REQ-033 Reset, then enable=1, then push 8'h10, 8'h20 -> RUN entered after the 2nd push; R2R_out=8'h10 with dac_update 4 cycles later; 8'h20 follows 4 cycles after that.
REQ-034 Hold sample_valid=1 with no strobe -> exactly 4 pushes; sample_ready=0; fifo_level=4; fifo_level saturates without overflow.
REQ-035 Stop pushing in RUN -> at the next strobe underrun=1 and R2R_out is held; underrun_clr together with a further empty strobe -> underrun stays 1.
REQ-036 Push on the same cycle as a pop with level=2 -> level stays 2; playout order is preserved.
REQ-037 Drop enable mid-period with R2R_out=8'h20 -> 8'h80 next cycle, no dac_update pulse; re-enable resumes from PRIME with FIFO contents intact.
REQ-038 Assert reset with 3 entries buffered -> fifo_level=0, R2R_out=8'h80, underrun=0 asynchronously; with R2R_DAC_UNDERRUN_CNT_EN defined, underrun_count=0.

Source files
------------

// File: rtl/r2r_dac_pkg.sv
// Shared definitions for the R2R DAC sample streamer: code width,
// ladder mid-scale code and the playback state type.
package r2r_dac_pkg;

    localparam int DAC_WIDTH = 8;
    localparam logic [DAC_WIDTH-1:0] MID_CODE = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/r2r_sample_fifo.sv
// Small synchronous sample FIFO. DEPTH must be a power of two so the
// read/write pointers wrap naturally. Overflowing pushes and
// underflowing pops are ignored.
module r2r_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Storage array; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/r2r_dac_streamer.sv
// Streams buffered 8-bit samples to an external R2R ladder at one code
// per DIV clocks. Playback starts once the FIFO is half full and parks
// the ladder at mid-scale whenever streaming is disabled.
// Optional feature: define R2R_DAC_UNDERRUN_CNT_EN to add a 16-bit
// saturating underrun_count output.
module r2r_dac_streamer
    import r2r_dac_pkg::*;
#(
    parameter int DIV        = 100_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DAC_WIDTH-1:0]          sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          underrun_clr,
    output logic [DAC_WIDTH-1:0]          R2R_out,
    output logic                          dac_update,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef R2R_DAC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_count
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(DIV);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 strobe;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DAC_WIDTH-1:0] fifo_dout;

    // The strobe only fires while still enabled so a disable and a load never collide.
    assign strobe       = (state == RUN) && enable && (cnt == CW'(DIV - 1));
    assign pop          = strobe && !fifo_empty;
    assign sample_ready = !fifo_full;

    r2r_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DAC_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (pop),
        .din   (sample_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Playback FSM with its period counter and the registered ladder outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            R2R_out    <= MID_CODE;
            dac_update <= 1'b0;
        end else begin
            dac_update <= pop;
            if (pop) begin
                R2R_out <= fifo_dout;
            end
            if (!enable) begin
                if (state != IDLE) begin
                    R2R_out <= MID_CODE;
                end
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                        cnt   <= '0;
                    end
                    PRIME: begin
                        if (fifo_level >= LW'(FIFO_DEPTH / 2)) begin
                            state <= RUN;
                        end
                        cnt <= '0;
                    end
                    RUN: begin
                        cnt <= strobe ? '0 : cnt + CW'(1);
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky underrun flag; a new empty strobe overrides a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (strobe && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

`ifdef R2R_DAC_UNDERRUN_CNT_EN
    // Saturating count of empty strobes; clear-and-increment together leaves a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (strobe && fifo_empty) begin
            if (underrun_clr) begin
                underrun_count <= 16'd1;
            end else if (underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end else if (underrun_clr) begin
            underrun_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_r2r_dac_streamer.sv
// Self-checking bench for r2r_dac_streamer (DIV=4, FIFO_DEPTH=4).
// Directed scenarios use fixed expectations; the random scenario is
// checked against a queue-based behavioural model of the streamer.
module tb_r2r_dac_streamer;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] sample_data = 8'h00;
    logic       sample_valid = 1'b0;
    logic       underrun_clr = 1'b0;
    logic       sample_ready;
    logic [7:0] R2R_out;
    logic       dac_update;
    logic       underrun;
    logic [2:0] fifo_level;
`ifdef R2R_DAC_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0] q[$];
    int         m_phase;   // 0 idle, 1 priming, 2 playing
    int         m_tick;    // cycles elapsed since playback started
    logic [7:0] m_out;
    logic       m_upd;
    logic       m_und;
    int         m_ucnt;
    bit         m_strobe;

    r2r_dac_streamer #(
        .DIV        (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .R2R_out      (R2R_out),
        .dac_update   (dac_update),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
`ifdef R2R_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        q.delete();
        m_phase  = 0;
        m_tick   = 0;
        m_out    = 8'h80;
        m_upd    = 1'b0;
        m_und    = 1'b0;
        m_ucnt   = 0;
        m_strobe = 1'b0;
    endfunction

    function automatic bit model_strobe_now();
        return (m_phase == 2) && enable && ((m_tick % DIV) == DIV - 1);
    endfunction

    function automatic void model_step();
        int sz;
        bit st;
        sz = q.size();
        st = model_strobe_now();
        m_strobe = st;
        m_upd = 1'b0;
        if (st && sz > 0) begin
            m_out = q.pop_front();
            m_upd = 1'b1;
        end
        if (sample_valid && sz < DEPTH) q.push_back(sample_data);
        if (st && sz == 0) begin
            m_und = 1'b1;
            if (underrun_clr) m_ucnt = 1;
            else if (m_ucnt < 65535) m_ucnt = m_ucnt + 1;
        end else if (underrun_clr) begin
            m_und = 1'b0;
            m_ucnt = 0;
        end
        if (!enable) begin
            if (m_phase != 0) m_out = 8'h80;
            m_phase = 0;
            m_tick = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (sz >= DEPTH / 2) begin
                m_phase = 2;
                m_tick = 0;
            end
        end else begin
            m_tick = m_tick + 1;
        end
    endfunction

    // Advance one clock edge, keep the model in step, and leave time for outputs to settle.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push_cycle(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data = d;
        tick();
        sample_valid = 1'b0;
    endtask

    // Returns the number of edges until dac_update is seen, or -1 on timeout.
    task automatic wait_update(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (dac_update === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (R2R_out !== 8'h80) begin n_fail++; $display("FAIL reset_r2r: got %h, required 80", R2R_out); end
        n_checks++;
        if (dac_update !== 1'b0) begin n_fail++; $display("FAIL reset_upd: got %b, required 0", dac_update); end
        n_checks++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_und: got %b, required 0", underrun); end
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", sample_ready); end
    endtask

    task automatic test_basic();
        int k;
        do_reset();
        enable = 1'b1;
        push_cycle(8'h10);
        push_cycle(8'h20);
        tick();  // playback starts on this edge
        wait_update(12, k);
        n_checks++;
        if (k != 4 || R2R_out !== 8'h10) begin
            n_fail++; $display("FAIL basic_first: edges=%0d code=%h, required 4 and 10", k, R2R_out);
        end
        wait_update(12, k);
        n_checks++;
        if (k != 4 || R2R_out !== 8'h20) begin
            n_fail++; $display("FAIL basic_second: edges=%0d code=%h, required 4 and 20", k, R2R_out);
        end
        tick();
        n_checks++;
        if (dac_update !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b, required 0", dac_update); end
    endtask

    task automatic test_full();
        int k;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            push_cycle(8'(i));
            n_checks++;
            if (sample_ready !== (i < DEPTH)) begin
                n_fail++; $display("FAIL full_ready push %0d: got %b, required %b", i, sample_ready, (i < DEPTH));
            end
        end
        n_checks++;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d, required 4", fifo_level); end
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_update(20, k);
            n_checks++;
            if (k < 0 || R2R_out !== 8'(i)) begin
                n_fail++; $display("FAIL full_order %0d: edges=%0d code=%h, required %h", i, k, R2R_out, 8'(i));
            end
        end
    endtask

    task automatic test_underrun();
        int k;
        do_reset();
        enable = 1'b1;
        push_cycle(8'hAA);
        push_cycle(8'hBB);
        wait_update(20, k);
        wait_update(20, k);
        n_checks++;
        if (k < 0 || R2R_out !== 8'hBB) begin n_fail++; $display("FAIL und_play: edges=%0d code=%h, required BB", k, R2R_out); end
        k = -1;
        for (int i = 1; i <= 2 * DIV; i++) begin
            tick();
            if (dac_update === 1'b1) begin k = -2; break; end
            if (underrun === 1'b1) begin k = i; break; end
        end
        n_checks++;
        if (k != DIV || R2R_out !== 8'hBB) begin
            n_fail++; $display("FAIL und_set: edges=%0d code=%h, required %0d and BB", k, R2R_out, DIV);
        end
        underrun_clr = 1'b1;
        tick();
        n_checks++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL und_clear: got %b, required 0", underrun); end
        for (int i = 0; i < 2 * DIV; i++) begin
            tick();
            if (m_strobe) break;
        end
        underrun_clr = 1'b0;
        n_checks++;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL und_set_wins: got %b, required 1", underrun); end
`ifdef R2R_DAC_UNDERRUN_CNT_EN
        n_checks++;
        if (underrun_count !== 16'd1) begin n_fail++; $display("FAIL und_count: got %0d, required 1", underrun_count); end
`endif
    endtask

    // Continues from the underrun scenario: buffer three samples, then reset asynchronously.
    task automatic test_reset_mid();
        enable = 1'b0;
        tick();
        push_cycle(8'h01);
        push_cycle(8'h02);
        push_cycle(8'h03);
        n_checks++;
        if (fifo_level !== 3'd3 || underrun !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: level=%0d und=%b, required 3 and 1", fifo_level, underrun);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (fifo_level !== 3'd0 || R2R_out !== 8'h80 || underrun !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: level=%0d code=%h und=%b, required 0 80 0", fifo_level, R2R_out, underrun);
        end
`ifdef R2R_DAC_UNDERRUN_CNT_EN
        n_checks++;
        if (underrun_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d, required 0", underrun_count); end
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_same_cycle();
        int k;
        do_reset();
        enable = 1'b1;
        push_cycle(8'h10);
        push_cycle(8'h20);
        tick();
        for (int i = 0; i < 2 * DIV && !model_strobe_now(); i++) tick();
        push_cycle(8'h30);
        n_checks++;
        if (fifo_level !== 3'd2 || dac_update !== 1'b1 || R2R_out !== 8'h10) begin
            n_fail++; $display("FAIL same_cycle: level=%0d upd=%b code=%h, required 2 1 10", fifo_level, dac_update, R2R_out);
        end
        wait_update(20, k);
        n_checks++;
        if (k != DIV || R2R_out !== 8'h20) begin n_fail++; $display("FAIL same_order2: edges=%0d code=%h, required 4 and 20", k, R2R_out); end
        wait_update(20, k);
        n_checks++;
        if (k != DIV || R2R_out !== 8'h30) begin n_fail++; $display("FAIL same_order3: edges=%0d code=%h, required 4 and 30", k, R2R_out); end
    endtask

    task automatic test_disable();
        int k;
        do_reset();
        enable = 1'b1;
        push_cycle(8'h10);
        push_cycle(8'h20);
        push_cycle(8'h30);
        push_cycle(8'h40);
        wait_update(20, k);
        wait_update(20, k);
        n_checks++;
        if (k < 0 || R2R_out !== 8'h20) begin n_fail++; $display("FAIL dis_pre: edges=%0d code=%h, required 20", k, R2R_out); end
        tick();
        enable = 1'b0;
        tick();
        n_checks++;
        if (R2R_out !== 8'h80 || dac_update !== 1'b0) begin
            n_fail++; $display("FAIL dis_mid: code=%h upd=%b, required 80 0", R2R_out, dac_update);
        end
        n_checks++;
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL dis_retain: level=%0d, required 2", fifo_level); end
        enable = 1'b1;
        wait_update(20, k);
        n_checks++;
        // one edge to PRIME, one to RUN, then a full period
        if (k != DIV + 2 || R2R_out !== 8'h30) begin
            n_fail++; $display("FAIL dis_resume: edges=%0d code=%h, required %0d and 30", k, R2R_out, DIV + 2);
        end
    endtask

    task automatic test_random();
        int vprob;
        int bad;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            vprob = (c < 400) ? 50 : 15;
            enable = ($urandom_range(0, 59) != 0);
            sample_valid = ($urandom_range(0, 99) < vprob);
            sample_data = 8'($urandom);
            underrun_clr = ($urandom_range(0, 9) == 0);
            tick();
            bad = 0;
            if (R2R_out !== m_out || dac_update !== m_upd || underrun !== m_und) bad = 1;
            if (fifo_level !== 3'(q.size()) || sample_ready !== (q.size() < DEPTH)) bad = 1;
`ifdef R2R_DAC_UNDERRUN_CNT_EN
            if (underrun_count !== 16'(m_ucnt)) bad = 1;
`endif
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random cyc %0d: code=%h upd=%b und=%b lvl=%0d rdy=%b, required %h %b %b %0d %b",
                         c, R2R_out, dac_update, underrun, fifo_level, sample_ready,
                         m_out, m_upd, m_und, q.size(), (q.size() < DEPTH));
            end
        end
        sample_valid = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_underrun();
        test_reset_mid();
        test_same_cycle();
        test_disable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
